// File: rtl/systolic_skew_fifo_bank.sv
// Per-row input FIFO bank for a systolic array. The fill side pushes the shared byte bus into
// every FIFO selected by write_enable. The drain side empties the FIFOs with a diagonal skew, so
// lane i starts popping i cycles after lane 0.
module systolic_skew_fifo_bank #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned ARRAY_SIZE = 9,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned PTR_W      = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_SIZE-1:0]             bus,
    input  logic [ARRAY_SIZE-1:0]            write_enable,
    input  logic                             fill_done,
    input  logic                             start,
    output logic [ARRAY_SIZE*DATA_SIZE-1:0]  row_data,
    output logic [ARRAY_SIZE-1:0]            row_valid,
    output logic [ARRAY_SIZE-1:0]            full,
    output logic [ARRAY_SIZE-1:0]            empty,
    output logic                             overflow,
    output logic                             busy,
    output logic                             done
);

    // Drain timer is wide enough to clear the deepest skew plus a full FIFO many times over.
    localparam int unsigned TW = PTR_W + 4;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    typedef logic [TW-1:0]    tmr_t;

    localparam cnt_t CntFull = cnt_t'(FIFO_DEPTH);
    localparam tmr_t TMax    = '1;

    typedef enum logic [1:0] {StIdle, StArmed, StDrain, StDone} state_e;

    state_e                          state_q, state_d;
    tmr_t                            t_q, t_d;
    logic                            fill_seen_q, fill_seen_d;
    logic                            overflow_q, overflow_d;
    cnt_t                            cnt_q    [ARRAY_SIZE];
    cnt_t                            cnt_d    [ARRAY_SIZE];
    ptr_t                            wr_ptr_q [ARRAY_SIZE];
    ptr_t                            wr_ptr_d [ARRAY_SIZE];
    ptr_t                            rd_ptr_q [ARRAY_SIZE];
    ptr_t                            rd_ptr_d [ARRAY_SIZE];
    logic [ARRAY_SIZE*DATA_SIZE-1:0] row_data_q, row_data_d;
    logic [ARRAY_SIZE-1:0]           row_valid_q, row_valid_d;
    logic [DATA_SIZE-1:0]            mem_q    [ARRAY_SIZE][FIFO_DEPTH];

    logic [ARRAY_SIZE-1:0]           pop;
    logic [ARRAY_SIZE-1:0]           push_ok;
    logic [ARRAY_SIZE-1:0]           lane_clear;

    // Per-lane push/pop decisions, pointer and count updates, output lane capture.
    always_comb begin
        pop         = '0;
        push_ok     = '0;
        lane_clear  = '0;
        overflow_d  = overflow_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        row_data_d  = row_data_q;
        row_valid_d = '0;
        for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
            lane_clear[i] = (t_q >= tmr_t'(i)) && (cnt_q[i] == '0);
            pop[i]        = (state_q == StDrain) && (t_q >= tmr_t'(i)) && (cnt_q[i] != '0);
            // A full FIFO still accepts a push when it is popping in the same cycle.
            push_ok[i]    = write_enable[i] && ((cnt_q[i] != CntFull) || pop[i]);
            if (write_enable[i] && !push_ok[i]) begin
                overflow_d = 1'b1;
            end
            if (push_ok[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i]                           = rd_ptr_q[i] + ptr_t'(1);
                row_data_d[i*DATA_SIZE +: DATA_SIZE] = mem_q[i][rd_ptr_q[i]];
                row_valid_d[i]                        = 1'b1;
            end
            if (push_ok[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end else if (!push_ok[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - cnt_t'(1);
            end
        end
    end

    // Drain sequencer: wait for start, then for fill completion, then run the skew timer.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        fill_seen_d = fill_seen_q | fill_done;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (fill_seen_q || fill_done) begin
                    state_d     = StDrain;
                    t_d         = '0;
                    fill_seen_d = 1'b0;
                end
            end
            StDrain: begin
                if (t_q != TMax) begin
                    t_d = t_q + tmr_t'(1);
                end
                if (&lane_clear) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and datapath state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            t_q         <= '0;
            fill_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            row_data_q  <= '0;
            row_valid_q <= '0;
            for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            fill_seen_q <= fill_seen_d;
            overflow_q  <= overflow_d;
            row_data_q  <= row_data_d;
            row_valid_q <= row_valid_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
            if (push_ok[i] && !reset) begin
                mem_q[i][wr_ptr_q[i]] <= bus;
            end
        end
    end

    // Status flags decoded from the registered counts.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
            full[i]  = (cnt_q[i] == CntFull);
            empty[i] = (cnt_q[i] == '0);
        end
    end

    assign row_data  = row_data_q;
    assign row_valid = row_valid_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_systolic_skew_fifo_bank.sv
// Directed bench for systolic_skew_fifo_bank: skewed drain, overflow, broadcast, sparse fill,
// start/fill handshake and reset during a drain.
module tb_systolic_skew_fifo_bank;

    localparam int DS = 8;
    localparam int AS = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic [DS-1:0]   bus;
    logic [AS-1:0]   write_enable;
    logic            fill_done;
    logic            start;
    logic [AS*DS-1:0] row_data;
    logic [AS-1:0]   row_valid;
    logic [AS-1:0]   full;
    logic [AS-1:0]   empty;
    logic            overflow;
    logic            busy;
    logic            done;

    systolic_skew_fifo_bank dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .write_enable (write_enable),
        .fill_done    (fill_done),
        .start        (start),
        .row_data     (row_data),
        .row_valid    (row_valid),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Expected drain contents per lane.
    int          exp_n [AS];
    logic [7:0]  exp_d [AS][40];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [AS-1:0] lanes, input logic [7:0] val);
        write_enable = lanes;
        bus          = val;
        tick();
        write_enable = '0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < AS; i++) exp_n[i] = 0;
    endtask

    // Pulse fill_done, then start; returns in the first DRAIN cycle (t=0).
    task automatic go(input string tag);
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check({tag, " armed busy"}, busy, 1'b1);
        tick();
    endtask

    // Checks every cycle from t=0 through the done pulse and one cycle after it.
    task automatic run_drain(input string tag, input int start_at);
        int e;
        logic [AS-1:0]    ev;
        logic [AS*DS-1:0] ed;
        logic [AS*DS-1:0] m;
        e = 0;
        for (int i = 0; i < AS; i++) if (i + exp_n[i] > e) e = i + exp_n[i];
        for (int t = 0; t <= e + 1; t++) begin
            ev = '0;
            ed = '0;
            m  = '0;
            for (int i = 0; i < AS; i++) begin
                if (t >= i + 1 && t <= i + exp_n[i]) begin
                    ev[i]          = 1'b1;
                    ed[i*DS +: DS] = exp_d[i][t-i-1];
                    m[i*DS +: DS]  = '1;
                end
            end
            check($sformatf("%s valid t=%0d", tag, t), row_valid, ev);
            check($sformatf("%s data t=%0d", tag, t), row_data & m, ed);
            check($sformatf("%s done t=%0d", tag, t), done, (t == e + 1));
            check($sformatf("%s busy t=%0d", tag, t), busy, 1'b1);
            start = (t == start_at);
            tick();
        end
        start = 1'b0;
        check({tag, " idle busy"}, busy, 1'b0);
        check({tag, " idle done"}, done, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        bus          = '0;
        write_enable = '0;
        fill_done    = 1'b0;
        start        = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst row_data", row_data, '0);
        check("rst row_valid", row_valid, '0);
        check("rst full", full, '0);
        check("rst empty", empty, 9'h1FF);
        check("rst overflow", overflow, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);

        // 1: skewed drain, three bytes per lane
        clear_exp();
        for (int i = 0; i < AS; i++) begin
            for (int k = 0; k < 3; k++) begin
                push(9'(1 << i), 8'(16 * i + k));
                exp_d[i][k] = 8'(16 * i + k);
            end
            exp_n[i] = 3;
        end
        check("s1 empty", empty, '0);
        go("s1");
        run_drain("s1", -1);
        check("s1 empty after", empty, 9'h1FF);

        // 2: overflow on lane 0
        clear_exp();
        for (int k = 0; k < 33; k++) begin
            push(9'h001, 8'(k));
            if (k < 32) exp_d[0][k] = 8'(k);
            if (k == 30) check("s2 full after 31", full[0], 1'b0);
            if (k == 31) begin
                check("s2 full after 32", full[0], 1'b1);
                check("s2 no ovf after 32", overflow, 1'b0);
            end
            if (k == 32) begin
                check("s2 ovf after 33", overflow, 1'b1);
                check("s2 still full", full, 9'h001);
            end
        end
        exp_n[0] = 32;
        go("s2");
        run_drain("s2", -1);
        check("s2 ovf sticky", overflow, 1'b1);
        check("s2 empty after", empty, 9'h1FF);

        // 3: broadcast
        clear_exp();
        push(9'h1FF, 8'hAA);
        for (int i = 0; i < AS; i++) begin
            exp_n[i]    = 1;
            exp_d[i][0] = 8'hAA;
        end
        check("s3 empty", empty, '0);
        check("s3 full", full, '0);
        go("s3");
        run_drain("s3", -1);

        // 4: sparse, lane 0 only
        clear_exp();
        push(9'h001, 8'h5C);
        push(9'h001, 8'hC5);
        exp_n[0]    = 2;
        exp_d[0][0] = 8'h5C;
        exp_d[0][1] = 8'hC5;
        go("s4");
        run_drain("s4", -1);

        // 5: start before fill_done; second start during drain is ignored
        clear_exp();
        push(9'h004, 8'h3E);
        exp_n[2]    = 1;
        exp_d[2][0] = 8'h3E;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("s5 armed busy c%0d", k), busy, 1'b1);
            check($sformatf("s5 armed valid c%0d", k), row_valid, '0);
            check($sformatf("s5 armed empty c%0d", k), empty, 9'h1FB);
            if (k == 4) fill_done = 1'b1;
            tick();
        end
        fill_done = 1'b0;
        run_drain("s5", 2);
        tick();
        check("s5 stays idle", busy, 1'b0);

        // 6: reset at t=4 of a full skewed drain
        clear_exp();
        check("s6 ovf before", overflow, 1'b1);
        for (int i = 0; i < AS; i++) begin
            for (int k = 0; k < 3; k++) push(9'(1 << i), 8'(16 * i + k));
        end
        go("s6");
        for (int t = 0; t < 4; t++) tick();
        check("s6 valid t=4", row_valid, 9'b000001110);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s6 busy", busy, 1'b0);
        check("s6 valid", row_valid, '0);
        check("s6 empty", empty, 9'h1FF);
        check("s6 overflow", overflow, 1'b0);
        check("s6 done", done, 1'b0);
        check("s6 row_data", row_data, '0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("s6 no done c%0d", k), {busy, done, row_valid}, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net against a stalled simulation.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
